// File: rtl/sync_params_pkg.sv
// Package: sync_params_pkg
// Shared defaults for the mediation register bank: data width, config-bus
// base address, reset value and the channel index type.
package sync_params_pkg;

    localparam int unsigned MEDREG_DATA_W    = 16;
    localparam int unsigned MEDREG_NUM_CH    = 3;
    localparam int unsigned MEDREG_ADDR_W    = 8;
    localparam logic [7:0]  MEDREG_BASE_ADDR = 8'h20;
    localparam int unsigned MEDREG_RST_VAL   = 0;

    // Index of a channel within the default-sized bank.
    typedef logic [$clog2(MEDREG_NUM_CH)-1:0] ch_idx_t;

    // Even parity bit for a data word: the stored bit makes the total count even.
    function automatic logic even_par(input logic [MEDREG_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/medregs_bank_ch.sv
// Module: medregs_bank_ch
// One double-buffered mediation register: write-side shadow, live copy,
// pending flag and sticky overrun flag. Optional even parity under the
// MEDREGS_PARITY_EN macro.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   wr_en, wr_data   shadow write strobe and data
//   commit           move pending shadow to live
//   ovr_clr          clear sticky overrun (and par_err when parity is built)
//   live             live value to the mediator
//   pending          shadow written since last commit
//   overrun          second write to a pending shadow before commit
//   par_bad          (MEDREGS_PARITY_EN) live copy currently fails its check
//   par_err          (MEDREGS_PARITY_EN) sticky, registered version of par_bad
module medregs_bank_ch
    import sync_params_pkg::*;
#(
    parameter int unsigned        DATA_W  = MEDREG_DATA_W,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] live,
    output logic              pending,
    output logic              overrun
`ifdef MEDREGS_PARITY_EN
    ,
    output logic              par_bad,
    output logic              par_err
`endif
);

    logic [DATA_W-1:0] shadow;

    // A commit in the same cycle as a write moves the old shadow to live
    // while the new data lands in the shadow, so pending stays set.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= RST_VAL;
            live    <= RST_VAL;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (commit && pending)
                live <= shadow;
            if (wr_en)
                shadow <= wr_data;

            if (wr_en)
                pending <= 1'b1;
            else if (commit)
                pending <= 1'b0;

            // Set has priority over clear.
            if (wr_en && pending && !commit)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

`ifdef MEDREGS_PARITY_EN
    logic shadow_par;
    logic live_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_par <= ^RST_VAL;
            live_par   <= ^RST_VAL;
            par_err    <= 1'b0;
        end else begin
            if (commit && pending)
                live_par <= shadow_par;
            if (wr_en)
                shadow_par <= ^wr_data;

            if (par_bad)
                par_err <= 1'b1;
            else if (ovr_clr)
                par_err <= 1'b0;
        end
    end

    assign par_bad = ^{live, live_par};
`endif

endmodule

// File: rtl/medregs_bank.sv
// Module: medregs_bank
// Bank of NUM_CH double-buffered mediation registers with a global commit
// and an address-decoded read port of fixed 1-cycle latency.
// Optional feature macro: MEDREGS_PARITY_EN (adds parity storage, par_err
// output, and parity-qualified rd_err).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   wr_en, wr_data        per-channel shadow write strobes / packed data
//   commit                pending shadows -> live, all channels at once
//   live_data             packed live values
//   pending, overrun      per-channel status
//   ovr_clr               clears overrun (and par_err)
//   rd_req, rd_addr       config read request
//   rd_valid, rd_data     read response, one cycle after rd_req
//   rd_err                out-of-range (or bad parity) response
//   par_err               (MEDREGS_PARITY_EN) sticky per-channel parity error
module medregs_bank
    import sync_params_pkg::*;
#(
    parameter int unsigned        DATA_W    = MEDREG_DATA_W,
    parameter int unsigned        NUM_CH    = MEDREG_NUM_CH,
    parameter int unsigned        ADDR_W    = MEDREG_ADDR_W,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(MEDREG_BASE_ADDR),
    parameter logic [DATA_W-1:0]  RST_VAL   = DATA_W'(MEDREG_RST_VAL)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        wr_en,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    input  logic                     commit,
    output logic [NUM_CH*DATA_W-1:0] live_data,
    output logic [NUM_CH-1:0]        pending,
    output logic [NUM_CH-1:0]        overrun,
    input  logic                     ovr_clr,
    input  logic                     rd_req,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_err
`ifdef MEDREGS_PARITY_EN
    ,
    output logic [NUM_CH-1:0]        par_err
`endif
);

`ifdef MEDREGS_PARITY_EN
    logic [NUM_CH-1:0] par_bad;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        medregs_bank_ch #(
            .DATA_W  (DATA_W),
            .RST_VAL (RST_VAL)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[i]),
            .wr_data (wr_data[i*DATA_W +: DATA_W]),
            .commit  (commit),
            .ovr_clr (ovr_clr),
            .live    (live_data[i*DATA_W +: DATA_W]),
            .pending (pending[i]),
            .overrun (overrun[i])
`ifdef MEDREGS_PARITY_EN
            ,
            .par_bad (par_bad[i]),
            .par_err (par_err[i])
`endif
        );
    end

    // One extra bit so addresses below BASE_ADDR wrap to a large offset.
    logic [ADDR_W:0]   offset;
    logic              in_range;
    logic [DATA_W-1:0] sel_data;
    logic              sel_bad;

    assign offset   = {1'b0, rd_addr} - {1'b0, BASE_ADDR};
    assign in_range = (offset < (ADDR_W+1)'(NUM_CH));

    always_comb begin
        sel_data = '0;
        sel_bad  = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (offset == (ADDR_W+1)'(i)) begin
                sel_data = live_data[i*DATA_W +: DATA_W];
`ifdef MEDREGS_PARITY_EN
                sel_bad  = par_bad[i];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= in_range ? sel_data : '0;
                rd_err  <= !in_range || sel_bad;
            end
        end
    end

endmodule

// File: tb/tb_medregs_bank.sv
// Testbench: tb_medregs_bank
// Directed scenarios followed by randomized traffic, all checked every
// cycle against a transaction-level model of the register bank.
module tb_medregs_bank;
    import sync_params_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned NC = 3;
    localparam int unsigned AW = 8;
    localparam int          BASE = 32'h20;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     wr_en;
    logic [NC*DW-1:0]  wr_data;
    logic              commit;
    logic [NC*DW-1:0]  live_data;
    logic [NC-1:0]     pending;
    logic [NC-1:0]     overrun;
    logic              ovr_clr;
    logic              rd_req;
    logic [AW-1:0]     rd_addr;
    logic              rd_valid;
    logic [DW-1:0]     rd_data;
    logic              rd_err;
`ifdef MEDREGS_PARITY_EN
    logic [NC-1:0]     par_err;
`endif

    medregs_bank #(
        .DATA_W    (DW),
        .NUM_CH    (NC),
        .ADDR_W    (AW),
        .BASE_ADDR (8'h20),
        .RST_VAL   (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .commit    (commit),
        .live_data (live_data),
        .pending   (pending),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_err    (rd_err)
`ifdef MEDREGS_PARITY_EN
        ,
        .par_err   (par_err)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Model state: the bank as the user sees it.
    logic [DW-1:0] shadow_m [NC];
    logic [DW-1:0] live_m   [NC];
    bit            pend_m   [NC];
    bit            ovr_m    [NC];

    function automatic logic [DW-1:0] wd(input int ch);
        return wr_data[ch*DW +: DW];
    endfunction

    // Apply one clock edge with the currently driven inputs, advance the
    // model and compare every visible output.
    task automatic step();
        logic [DW-1:0] nsh [NC];
        logic [DW-1:0] nlv [NC];
        bit            npd [NC];
        bit            nov [NC];
        bit            ev;
        logic [DW-1:0] ed;
        bit            ee;
        int            idx;
        logic [NC*DW-1:0] exp_live;
        logic [NC-1:0]    exp_pend, exp_ovr;

        ev = rd_req;
        idx = int'(rd_addr) - BASE;
        if (idx >= 0 && idx < int'(NC)) begin
            ed = live_m[idx];
            ee = 1'b0;
        end else begin
            ed = '0;
            ee = 1'b1;
        end

        for (int i = 0; i < int'(NC); i++) begin
            nsh[i] = shadow_m[i];
            nlv[i] = live_m[i];
            npd[i] = pend_m[i];
            nov[i] = ovr_m[i];
            if (commit && pend_m[i]) begin
                nlv[i] = shadow_m[i];
                npd[i] = 1'b0;
            end
            if (wr_en[i]) begin
                nsh[i] = wd(i);
                npd[i] = 1'b1;
            end
            if (wr_en[i] && pend_m[i] && !commit) nov[i] = 1'b1;
            else if (ovr_clr)                      nov[i] = 1'b0;
            if (rst) begin
                nsh[i] = '0; nlv[i] = '0; npd[i] = 1'b0; nov[i] = 1'b0;
            end
        end
        if (rst) ev = 1'b0;

        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NC); i++) begin
            shadow_m[i] = nsh[i];
            live_m[i]   = nlv[i];
            pend_m[i]   = npd[i];
            ovr_m[i]    = nov[i];
            exp_live[i*DW +: DW] = nlv[i];
            exp_pend[i] = npd[i];
            exp_ovr[i]  = nov[i];
        end
        check("live_data", 64'(live_data), 64'(exp_live));
        check("pending",   64'(pending),   64'(exp_pend));
        check("overrun",   64'(overrun),   64'(exp_ovr));
        check("rd_valid",  64'(rd_valid),  64'(ev));
        if (ev) begin
            check("rd_data", 64'(rd_data), 64'(ed));
            check("rd_err",  64'(rd_err),  64'(ee));
        end
    endtask

    task automatic idle();
        rst = 1'b0; wr_en = '0; commit = 1'b0; ovr_clr = 1'b0; rd_req = 1'b0;
    endtask

    task automatic wr(input int ch, input logic [DW-1:0] v);
        wr_en[ch] = 1'b1;
        wr_data[ch*DW +: DW] = v;
    endtask

    initial begin
        wr_data = '0; rd_addr = '0;
        idle();
        for (int i = 0; i < int'(NC); i++) begin
            shadow_m[i] = 'x; live_m[i] = 'x; pend_m[i] = 0; ovr_m[i] = 0;
        end

        // 1: reset, then read 0x21
        rst = 1'b1; step(); step();
        idle(); rd_req = 1'b1; rd_addr = 8'h21; step();
        idle(); step();

        // 2: write ch1 without commit, then commit
        wr(1, 16'hBEEF); step();
        check("t2_pending", 64'(pending), 64'(3'b010));
        check("t2_live1_hold", 64'(live_data[DW +: DW]), 64'h0);
        idle(); commit = 1'b1; step();
        check("t2_live1", 64'(live_data[DW +: DW]), 64'hBEEF);
        idle(); step();

        // 3: overrun on ch0, newest wins, then clear
        wr(0, 16'h0001); step();
        idle(); wr(0, 16'h0002); step();
        check("t3_ovr", 64'(overrun), 64'(3'b001));
        idle(); commit = 1'b1; step();
        check("t3_live0", 64'(live_data[0 +: DW]), 64'h0002);
        idle(); ovr_clr = 1'b1; step();
        check("t3_clr", 64'(overrun), 64'h0);

        // 4: commit and write ch2 in the same cycle
        idle(); wr(2, 16'h1111); step();
        idle(); commit = 1'b1; wr(2, 16'h2222); step();
        check("t4_live2", 64'(live_data[2*DW +: DW]), 64'h1111);
        check("t4_pend2", 64'(pending[2]), 64'h1);
        check("t4_ovr2", 64'(overrun[2]), 64'h0);
        idle(); commit = 1'b1; step();
        check("t4_shadow2", 64'(live_data[2*DW +: DW]), 64'h2222);

        // 5: back-to-back out-of-range reads
        idle(); rd_req = 1'b1; rd_addr = 8'h1F; step();
        check("t5_err_lo", 64'(rd_err), 64'h1);
        rd_addr = 8'h23; step();
        check("t5_err_hi", 64'(rd_err), 64'h1);
        idle(); step();

        // 6: read during a commit sees the old value; reset kills a read
        wr(0, 16'hCAFE); step();
        idle(); commit = 1'b1; rd_req = 1'b1; rd_addr = 8'h20; step();
        check("t6_old", 64'(rd_data), 64'h0002);
        idle(); rd_req = 1'b1; rd_addr = 8'h20; rst = 1'b1; step();
        check("t6_rst", 64'(rd_valid), 64'h0);
        idle(); step();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            idle();
            rst     = ($urandom_range(0, 79) == 0);
            for (int i = 0; i < int'(NC); i++)
                if ($urandom_range(0, 2) == 0) wr(i, 16'($urandom));
            commit  = ($urandom_range(0, 3) == 0);
            ovr_clr = ($urandom_range(0, 7) == 0);
            rd_req  = ($urandom_range(0, 1) == 0);
            rd_addr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(8'h1E, 8'h24));
            step();
        end
        idle(); step();

`ifdef MEDREGS_PARITY_EN
        // 7: corrupt live0 and expect a parity error
        check("t7_par_clean", 64'(par_err), 64'h0);
        force dut.g_ch[0].u_ch.live = live_data[0 +: DW] ^ 16'h0001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t7_par_err", 64'(par_err[0]), 64'h1);
        rd_req = 1'b1; rd_addr = 8'h20;
        @(posedge clk); #1;
        rd_req = 1'b0;
        check("t7_rd_err", 64'(rd_err), 64'h1);
        release dut.g_ch[0].u_ch.live;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
